acq_ram_writer: RTL and testbench

- Acquisition-buffer writer, directly downstream of the flux-timing disc reader.
- Consumes its timing bytes (DATA/WRITE) and drives the DiscReader RUN enable.
- Writes the bytes sequentially into external async SRAM and stops on index count, buffer full or host abort.
- Sits between the disc reader and the SRAM arbiter / host status registers.

---
 rtl/acq_pkg.sv | 27 ++
 rtl/sram_write_port.sv | 77 +++++++
 rtl/acq_ram_writer.sv | 124 ++++++++++++
 tb/tb_acq_ram_writer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and defaults for the acquisition RAM writer.
// The ACQ_WAIT_INDEX_EN macro adds the ARMED state (wait for first index before capture).
package acq_pkg;

    localparam int ADDR_W_DEF    = 19;
    localparam int IDX_CNT_W_DEF = 8;

    // Marker byte the disc reader emits on counter overflow; low 7 bits are zero.
    localparam logic [7:0] OVERFLOW_MARKER = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
`ifdef ACQ_WAIT_INDEX_EN
        ST_ARMED    = 3'd1,
`endif
        ST_RUNNING  = 3'd2,
        ST_STOPPING = 3'd3,
        ST_DONE     = 3'd4
    } acq_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE    = 2'd0,
        ENG_STROBE  = 2'd1,
        ENG_RECOVER = 2'd2
    } eng_state_t;

endpackage

// File: rtl/sram_write_port.sv
// Two-cycle async SRAM write engine (STROBE, RECOVER) with a one-entry pending slot.
module sram_write_port
    import acq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              accept_en,
    input  logic              full,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic [7:0]        wr_data,
    input  logic              wr_strobe,
    output logic [ADDR_W-1:0] sram_a,
    output logic [7:0]        sram_d,
    output logic              sram_we_n,
    output logic              busy,
    output logic              slot_full,
    output logic              last_addr_written,
    output logic              recover_done,
    output logic              overrun_set
);

    eng_state_t        eng, eng_nxt;
    logic [7:0]        slot_data;
    logic              wr, engine_free, discard;
    logic              issue_slot, issue_direct, store_slot, issue;
    logic [ADDR_W-1:0] issue_addr;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        busy              = (eng != ENG_IDLE);
        recover_done      = (eng == ENG_RECOVER);
        last_addr_written = recover_done && (sram_a == '1);
        wr                = wr_strobe && accept_en;
        // The end of RECOVER is also a free issue slot, sustaining one byte per two cycles.
        engine_free       = (eng != ENG_STROBE);
        discard           = full || last_addr_written;
        issue_addr        = recover_done ? sram_a + 1'b1 : next_addr;
        issue_slot        = engine_free && slot_full && !discard;
        issue_direct      = engine_free && !slot_full && wr && !discard;
        store_slot        = !engine_free && !slot_full && wr && !discard;
        overrun_set       = wr && slot_full && !discard;
        issue             = issue_slot || issue_direct;
        eng_nxt           = ENG_IDLE;
        if (issue)
            eng_nxt = ENG_STROBE;
        else if (eng == ENG_STROBE)
            eng_nxt = ENG_RECOVER;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            eng       <= ENG_IDLE;
            slot_full <= 1'b0;
            sram_a    <= '0;
            sram_d    <= '0;
            sram_we_n <= 1'b1;
        end else begin
            eng       <= eng_nxt;
            sram_we_n <= !issue;
            slot_full <= store_slot || (slot_full && !issue_slot && !discard);
            if (issue) begin
                sram_a <= issue_addr;
                sram_d <= issue_slot ? slot_data : wr_data;
            end
        end
    end

    // NOTE: the slot payload is not reset; slot_full alone says whether it is meaningful.
    always_ff @(posedge CLOCK) begin
        if (store_slot)
            slot_data <= wr_data;
    end

endmodule

// File: rtl/acq_ram_writer.sv
// Acquisition buffer writer: captures disc-reader timing bytes into SRAM until index/full/abort.
// Optional ACQ_WAIT_INDEX_EN: START arms and capture begins on the first index rising edge.
module acq_ram_writer
    import acq_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int IDX_CNT_W = IDX_CNT_W_DEF
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 ADDR_LOAD,
    input  logic [ADDR_W-1:0]    ADDR_IN,
    input  logic [IDX_CNT_W-1:0] IDX_STOP_COUNT,
    input  logic                 FD_INDEX_IN,
    input  logic [7:0]           DR_DATA,
    input  logic                 DR_WRITE,
    output logic                 RUN,
    output logic [ADDR_W-1:0]    SRAM_A,
    output logic [7:0]           SRAM_D,
    output logic                 SRAM_WE_N,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 FULL,
    output logic                 OVERRUN,
    output logic [IDX_CNT_W-1:0] IDX_SEEN,
    output logic [ADDR_W-1:0]    ADDR_OUT
);

    acq_state_t           state, state_nxt;
    logic                 idx_prev, idx_rise, idx_stop_hit, idle_or_done, start_ok;
    logic                 accept_en, eng_busy, slot_full, last_addr_written, recover_done, overrun_set;
    logic [IDX_CNT_W-1:0] idx_inc;

    sram_write_port #(.ADDR_W(ADDR_W)) u_port (
        .CLOCK             (CLOCK),
        .RESET             (RESET),
        .accept_en         (accept_en),
        .full              (FULL),
        .next_addr         (ADDR_OUT),
        .wr_data           (DR_DATA),
        .wr_strobe         (DR_WRITE),
        .sram_a            (SRAM_A),
        .sram_d            (SRAM_D),
        .sram_we_n         (SRAM_WE_N),
        .busy              (eng_busy),
        .slot_full         (slot_full),
        .last_addr_written (last_addr_written),
        .recover_done      (recover_done),
        .overrun_set       (overrun_set)
    );

    always_comb begin
        idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
        start_ok     = START && idle_or_done;
        accept_en    = (state == ST_RUNNING) || (state == ST_STOPPING);
        idx_rise     = FD_INDEX_IN && !idx_prev;
        idx_inc      = (IDX_SEEN == '1) ? IDX_SEEN : IDX_SEEN + 1'b1;
        idx_stop_hit = idx_rise && (IDX_STOP_COUNT != '0) && (idx_inc == IDX_STOP_COUNT);
        BUSY         = !idle_or_done;
        DONE         = (state == ST_DONE);

        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
`ifdef ACQ_WAIT_INDEX_EN
                if (START) state_nxt = ST_ARMED;
`else
                if (START) state_nxt = ST_RUNNING;
`endif
            end
`ifdef ACQ_WAIT_INDEX_EN
            ST_ARMED: begin
                if (ABORT)         state_nxt = ST_DONE;
                else if (idx_rise) state_nxt = ST_RUNNING;
            end
`endif
            ST_RUNNING: begin
                if (ABORT || FULL || last_addr_written || idx_stop_hit)
                    state_nxt = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (!eng_busy && !slot_full && !DR_WRITE)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            RUN      <= 1'b0;
            idx_prev <= 1'b0;
            FULL     <= 1'b0;
            OVERRUN  <= 1'b0;
            IDX_SEEN <= '0;
            ADDR_OUT <= '0;
        end else begin
            state    <= state_nxt;
            RUN      <= (state_nxt == ST_RUNNING);
            idx_prev <= FD_INDEX_IN;

            if (start_ok)               FULL <= 1'b0;
            else if (last_addr_written) FULL <= 1'b1;

            if (start_ok)         OVERRUN <= 1'b0;
            else if (overrun_set) OVERRUN <= 1'b1;

            if (start_ok)
                IDX_SEEN <= '0;
            else if (state == ST_RUNNING && idx_rise)
                IDX_SEEN <= idx_inc;

            // The top address is never passed: the last slot stays the final write address.
            if (ADDR_LOAD && idle_or_done)
                ADDR_OUT <= ADDR_IN;
            else if (recover_done && !last_addr_written)
                ADDR_OUT <= ADDR_OUT + 1'b1;
        end
    end

endmodule

// File: tb/tb_acq_ram_writer.sv
// Directed self-checking bench for acq_ram_writer; follows ACQ_WAIT_INDEX_EN when defined.
module tb_acq_ram_writer;

    localparam int AW = 19;
    localparam int IW = 8;

    logic          CLOCK = 1'b0;
    logic          RESET, START, ABORT, ADDR_LOAD, FD_INDEX_IN, DR_WRITE;
    logic [AW-1:0] ADDR_IN;
    logic [IW-1:0] IDX_STOP_COUNT;
    logic [7:0]    DR_DATA;
    logic          RUN, SRAM_WE_N, BUSY, DONE, FULL, OVERRUN;
    logic [AW-1:0] SRAM_A, ADDR_OUT;
    logic [7:0]    SRAM_D;
    logic [IW-1:0] IDX_SEEN;

    int            checks   = 0;
    int            failures = 0;
    int            wr_cnt   = 0;
    int            base;
    logic [AW-1:0] wa [32];
    logic [7:0]    wd [32];

    acq_ram_writer #(.ADDR_W(AW), .IDX_CNT_W(IW)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .ADDR_LOAD(ADDR_LOAD), .ADDR_IN(ADDR_IN), .IDX_STOP_COUNT(IDX_STOP_COUNT),
        .FD_INDEX_IN(FD_INDEX_IN), .DR_DATA(DR_DATA), .DR_WRITE(DR_WRITE),
        .RUN(RUN), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_WE_N(SRAM_WE_N),
        .BUSY(BUSY), .DONE(DONE), .FULL(FULL), .OVERRUN(OVERRUN),
        .IDX_SEEN(IDX_SEEN), .ADDR_OUT(ADDR_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    // Record every SRAM write strobe mid-cycle.
    always @(negedge CLOCK) begin
        if (SRAM_WE_N === 1'b0) begin
            if (wr_cnt < 32) begin
                wa[wr_cnt] = SRAM_A;
                wd[wr_cnt] = SRAM_D;
            end
            wr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm();
`ifdef ACQ_WAIT_INDEX_EN
        FD_INDEX_IN = 1'b1;
        tick();
        FD_INDEX_IN = 1'b0;
        tick();
`endif
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && DONE !== 1'b1; i++)
            tick();
    endtask

    task automatic write_byte(input logic [7:0] d);
        DR_DATA  = d;
        DR_WRITE = 1'b1;
        tick();
        DR_WRITE = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; ABORT = 1'b0; ADDR_LOAD = 1'b0; FD_INDEX_IN = 1'b0;
        DR_WRITE = 1'b0; DR_DATA = 8'h00; ADDR_IN = '0; IDX_STOP_COUNT = '0;
        tick();
        tick();
        check("rst_we_n", SRAM_WE_N, 1);
        check("rst_run", RUN, 0);
        check("rst_addr", ADDR_OUT, 0);
        check("rst_flags", {BUSY, DONE, FULL, OVERRUN}, 0);
        check("rst_idx", IDX_SEEN, 0);
        RESET = 1'b0;
        tick();

        // ABORT while idle does nothing.
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        check("abort_idle_busy", BUSY, 0);
        check("abort_idle_done", DONE, 0);

        // Basic writes at 0x00100.
        ADDR_IN = 19'h00100; ADDR_LOAD = 1'b1; tick(); ADDR_LOAD = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        arm();
        check("basic_run", RUN, 1);
        check("basic_busy", BUSY, 1);
        base = wr_cnt;
        write_byte(8'h12);
        tick();
        write_byte(8'h34);
        repeat (4) tick();
        check("basic_count", wr_cnt - base, 2);
        check("basic_a0", wa[base], 32'h00100);
        check("basic_d0", wd[base], 32'h12);
        check("basic_a1", wa[base+1], 32'h00101);
        check("basic_d1", wd[base+1], 32'h34);
        check("basic_addr_out", ADDR_OUT, 32'h00102);
        check("basic_overrun", OVERRUN, 0);
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        wait_done();
        check("abort_done", DONE, 1);
        check("abort_busy", BUSY, 0);
        check("abort_run", RUN, 0);

        // Overrun: three back-to-back bytes, third one dropped.
        START = 1'b1; tick(); START = 1'b0;
        arm();
        check("ovr_done_cleared", DONE, 0);
        base = wr_cnt;
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        repeat (6) tick();
        check("ovr_count", wr_cnt - base, 2);
        check("ovr_a0", wa[base], 32'h00102);
        check("ovr_d0", wd[base], 32'hA1);
        check("ovr_a1", wa[base+1], 32'h00103);
        check("ovr_d1", wd[base+1], 32'hA2);
        check("ovr_flag", OVERRUN, 1);
        check("ovr_addr_out", ADDR_OUT, 32'h00104);
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        wait_done();

        // Index stop after two rising edges.
        IDX_STOP_COUNT = 8'd2;
        START = 1'b1; tick(); START = 1'b0;
        arm();
        check("idx_ovr_cleared", OVERRUN, 0);
        check("idx_start", IDX_SEEN, 0);
        repeat (10) tick();
        FD_INDEX_IN = 1'b1; tick(); FD_INDEX_IN = 1'b0;
        check("idx_one", IDX_SEEN, 1);
        check("idx_run_still", RUN, 1);
        repeat (39) tick();
        FD_INDEX_IN = 1'b1;
        check("idx_run_before", RUN, 1);
        tick();
        FD_INDEX_IN = 1'b0;
        check("idx_two", IDX_SEEN, 2);
        check("idx_run_fell", RUN, 0);
        wait_done();
        check("idx_done", DONE, 1);
        check("idx_busy", BUSY, 0);
        IDX_STOP_COUNT = '0;

        // Buffer full at the top of the address space.
        ADDR_IN = 19'h7FFFE; ADDR_LOAD = 1'b1; START = 1'b1; tick();
        ADDR_LOAD = 1'b0; START = 1'b0;
        arm();
        check("full_cleared_idx", IDX_SEEN, 0);
        base = wr_cnt;
        write_byte(8'hB1);
        tick();
        write_byte(8'hB2);
        tick();
        write_byte(8'hB3);
        repeat (4) tick();
        check("full_count", wr_cnt - base, 2);
        check("full_a0", wa[base], 32'h7FFFE);
        check("full_d0", wd[base], 32'hB1);
        check("full_a1", wa[base+1], 32'h7FFFF);
        check("full_d1", wd[base+1], 32'hB2);
        check("full_flag", FULL, 1);
        check("full_addr_out", ADDR_OUT, 32'h7FFFF);
        check("full_overrun", OVERRUN, 0);
        wait_done();
        check("full_done", DONE, 1);

        // Reset during a STROBE cycle.
        ADDR_IN = 19'h00020; ADDR_LOAD = 1'b1; START = 1'b1; tick();
        ADDR_LOAD = 1'b0; START = 1'b0;
        arm();
        check("rstw_full_cleared", FULL, 0);
        write_byte(8'h55);
        check("rstw_strobe", SRAM_WE_N, 0);
        check("rstw_addr", SRAM_A, 32'h00020);
        RESET = 1'b1;
        tick();
        check("rstw_we_n", SRAM_WE_N, 1);
        check("rstw_run", RUN, 0);
        check("rstw_addr_out", ADDR_OUT, 0);
        check("rstw_flags", {BUSY, DONE, FULL, OVERRUN}, 0);
        RESET = 1'b0;
        tick();

        // RUN timing after START.
        START = 1'b1; tick(); START = 1'b0;
`ifdef ACQ_WAIT_INDEX_EN
        check("feat_armed_run", RUN, 0);
        check("feat_armed_busy", BUSY, 1);
        repeat (9) tick();
        check("feat_wait_run", RUN, 0);
        FD_INDEX_IN = 1'b1; tick(); FD_INDEX_IN = 1'b0;
        check("feat_run", RUN, 1);
        check("feat_idx", IDX_SEEN, 0);
`else
        check("feat_run", RUN, 1);
        check("feat_busy", BUSY, 1);
`endif
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        wait_done();
        check("feat_done", DONE, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
